// File: rtl/readout_sequencer.sv
// Frame sequencer for the serial-to-parallel readout shift register: gathers WIDTH
// contiguous bits, pulses the register load, and hands the parallel word downstream.
module readout_sequencer #(
    parameter int WIDTH  = 512,
    parameter int CNT_W  = $clog2(WIDTH) + 1,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clr_status,
    input  logic              s_bit,
    input  logic              s_valid,
    input  logic              s_sof,
    output logic              s_ready,
    output logic              sr_shift_in,
    output logic              sr_load,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_count,
    output logic              err_gap,
    output logic              err_overrun
);

    typedef enum logic [1:0] {IDLE, ARM, SHIFT, LOAD} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             accept;
    logic             gap_set;
    logic             ovr_set;
    logic             in_load;

    // The register shifts on every non-load cycle, so the serial path is a plain wire.
    assign sr_shift_in = s_bit;
    assign accept      = s_valid && s_ready;
    assign cnt_inc     = cnt + 1'b1;
    assign in_load     = (state == LOAD);
    assign ovr_set     = in_load && frame_valid && !frame_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gap_set = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable) state_n = ARM;
            end
            ARM: begin
                if (!enable) begin
                    state_n = IDLE;
                end else if (accept && s_sof) begin
                    cnt_n   = CNT_W'(1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (!accept) begin
                    gap_set = 1'b1;
                    cnt_n   = '0;
                    state_n = ARM;
                end else if (s_sof) begin
                    // A new sof mid-frame restarts the count on the new frame.
                    gap_set = 1'b1;
                    cnt_n   = CNT_W'(1);
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CNT_W'(WIDTH)) state_n = LOAD;
                end
            end
            LOAD: begin
                cnt_n   = '0;
                state_n = enable ? ARM : IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            s_ready     <= 1'b0;
            sr_load     <= 1'b0;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            frame_count <= '0;
            err_gap     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            // Outputs are decoded from the next state so they line up with the state register.
            s_ready <= (state_n == ARM) || (state_n == SHIFT);
            sr_load <= (state_n == LOAD);
            busy    <= (state_n != IDLE);

            if (in_load) frame_count <= frame_count + 1'b1;

            // A load always leaves a fresh frame pending, even if the old one was consumed now.
            if (in_load)
                frame_valid <= 1'b1;
            else if (frame_valid && frame_ready)
                frame_valid <= 1'b0;

            err_gap     <= gap_set | (err_gap & ~clr_status);
            err_overrun <= ovr_set | (err_overrun & ~clr_status);
        end
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer at WIDTH=8, with a behavioural model of the
// external shift register so loaded words can be checked.
module tb_readout_sequencer;

    localparam int WIDTH  = 8;
    localparam int CNT_W  = 4;
    localparam int FCNT_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              enable = 1'b0;
    logic              clr_status = 1'b0;
    logic              s_bit = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_sof = 1'b0;
    logic              frame_ready = 1'b0;
    logic              s_ready, sr_shift_in, sr_load, frame_valid, busy, err_gap, err_overrun;
    logic [FCNT_W-1:0] frame_count;

    logic [WIDTH-1:0]  sr = '0;
    logic [WIDTH-1:0]  data_out = '0;
    int                load_cnt = 0;
    int                tests = 0;
    int                fails = 0;

    readout_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clr_status(clr_status),
        .s_bit(s_bit), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
        .sr_shift_in(sr_shift_in), .sr_load(sr_load), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .busy(busy), .frame_count(frame_count),
        .err_gap(err_gap), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // External shift register: shift left into bit 0 unless loading.
    always @(posedge clk) begin
        if (sr_load) begin
            data_out <= sr;
            load_cnt <= load_cnt + 1;
        end else begin
            sr <= {sr[WIDTH-2:0], sr_shift_in};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        enable = 0; clr_status = 0; s_valid = 0; s_sof = 0; s_bit = 0; frame_ready = 0;
        reset = 1;
        repeat (2) tick();
        reset = 0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, input logic sof_first);
        for (int i = 0; i < n; i++) begin
            s_valid = 1;
            s_bit   = v[7-i];
            s_sof   = (i == 0) && sof_first;
            tick();
        end
        s_valid = 0; s_sof = 0; s_bit = 0;
    endtask

    task automatic test_reset;
        #1 reset = 1;
        #1;
        tests++;
        if ({busy, s_ready, sr_load, frame_valid, err_gap, err_overrun, frame_count} !== '0) begin
            fails++;
            $display("FAIL reset_async: outputs %b expected all zero",
                     {busy, s_ready, sr_load, frame_valid, err_gap, err_overrun, frame_count});
        end
        apply_reset();
        tick();
        tests++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b s_ready=%b expected 0 0", busy, s_ready);
        end
    endtask

    task automatic test_basic;
        apply_reset();
        enable = 1;
        tick();
        tests++;
        if (s_ready !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_arm: s_ready=%b busy=%b expected 1 1", s_ready, busy);
        end
        send_bits(8'hB2, 8, 1);
        tests++;
        if (sr_load !== 1'b1 || frame_valid !== 1'b0 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_load: sr_load=%b frame_valid=%b s_ready=%b expected 1 0 0",
                     sr_load, frame_valid, s_ready);
        end
        tick();
        tests++;
        if (sr_load !== 1'b0 || frame_valid !== 1'b1 || data_out !== 8'hB2 ||
            frame_count !== 4'd1 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_frame: load=%b fv=%b data=%h cnt=%0d rdy=%b expected 0 1 b2 1 1",
                     sr_load, frame_valid, data_out, frame_count, s_ready);
        end
        frame_ready = 1;
        tick();
        frame_ready = 0;
        tests++;
        if (frame_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_consume: frame_valid=%b expected 0", frame_valid);
        end
    endtask

    task automatic test_overrun;
        apply_reset();
        enable = 1;
        tick();
        send_bits(8'hB2, 8, 1);
        tick();
        send_bits(8'h5C, 8, 1);
        tests++;
        if (sr_load !== 1'b1 || err_overrun !== 1'b0 || frame_valid !== 1'b1) begin
            fails++;
            $display("FAIL overrun_load: load=%b ovr=%b fv=%b expected 1 0 1",
                     sr_load, err_overrun, frame_valid);
        end
        tick();
        tests++;
        if (err_overrun !== 1'b1 || frame_valid !== 1'b1 || data_out !== 8'h5C ||
            frame_count !== 4'd2) begin
            fails++;
            $display("FAIL overrun_flag: ovr=%b fv=%b data=%h cnt=%0d expected 1 1 5c 2",
                     err_overrun, frame_valid, data_out, frame_count);
        end
        clr_status = 1;
        tick();
        clr_status = 0;
        tests++;
        if (err_overrun !== 1'b0 || frame_count !== 4'd2) begin
            fails++;
            $display("FAIL overrun_clear: ovr=%b cnt=%0d expected 0 2", err_overrun, frame_count);
        end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        enable = 1;
        tick();
        send_bits(8'hA5, 8, 1);
        tick();
        send_bits(8'h3C, 8, 1);
        frame_ready = 1;
        tick();
        tests++;
        if (frame_valid !== 1'b1 || err_overrun !== 1'b0 || data_out !== 8'h3C) begin
            fails++;
            $display("FAIL b2b_load_handshake: fv=%b ovr=%b data=%h expected 1 0 3c",
                     frame_valid, err_overrun, data_out);
        end
        tick();
        frame_ready = 0;
        tests++;
        if (frame_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_consume: frame_valid=%b expected 0", frame_valid);
        end
    endtask

    task automatic test_gap;
        int l0;
        apply_reset();
        enable = 1;
        tick();
        l0 = load_cnt;
        send_bits(8'hF8, 5, 1);
        tick();
        tests++;
        if (err_gap !== 1'b1 || s_ready !== 1'b1 || sr_load !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL gap_flag: gap=%b rdy=%b load=%b busy=%b expected 1 1 0 1",
                     err_gap, s_ready, sr_load, busy);
        end
        send_bits(8'hA5, 8, 1);
        tests++;
        if (sr_load !== 1'b1 || load_cnt !== l0) begin
            fails++;
            $display("FAIL gap_reload: load=%b loads=%0d expected 1 %0d", sr_load, load_cnt, l0);
        end
        tick();
        tests++;
        if (data_out !== 8'hA5 || frame_count !== 4'd1 || load_cnt !== l0 + 1) begin
            fails++;
            $display("FAIL gap_frame: data=%h cnt=%0d loads=%0d expected a5 1 %0d",
                     data_out, frame_count, load_cnt, l0 + 1);
        end
    endtask

    task automatic test_resync;
        int l0;
        apply_reset();
        enable = 1;
        tick();
        l0 = load_cnt;
        send_bits(8'hE0, 3, 1);
        send_bits(8'h3C, 1, 1);
        tests++;
        if (err_gap !== 1'b1 || sr_load !== 1'b0) begin
            fails++;
            $display("FAIL resync_flag: gap=%b load=%b expected 1 0", err_gap, sr_load);
        end
        send_bits(8'h78, 7, 0);
        tests++;
        if (sr_load !== 1'b1 || load_cnt !== l0) begin
            fails++;
            $display("FAIL resync_load: load=%b loads=%0d expected 1 %0d", sr_load, load_cnt, l0);
        end
        tick();
        tests++;
        if (data_out !== 8'h3C || load_cnt !== l0 + 1) begin
            fails++;
            $display("FAIL resync_data: data=%h loads=%0d expected 3c %0d",
                     data_out, load_cnt, l0 + 1);
        end
    endtask

    task automatic test_enable;
        int l0;
        apply_reset();
        enable = 1;
        tick();
        send_bits(8'h96, 3, 1);
        enable = 0;
        send_bits(8'hB0, 5, 0);
        tests++;
        if (sr_load !== 1'b1) begin
            fails++;
            $display("FAIL enable_finish: sr_load=%b expected 1", sr_load);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || data_out !== 8'h96 || frame_count !== 4'd1) begin
            fails++;
            $display("FAIL enable_idle: busy=%b rdy=%b data=%h cnt=%0d expected 0 0 96 1",
                     busy, s_ready, data_out, frame_count);
        end
        enable = 1;
        tick();
        l0 = load_cnt;
        send_bits(8'hFF, 4, 0);
        tick();
        tests++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || err_gap !== 1'b0 || load_cnt !== l0 ||
            frame_count !== 4'd1) begin
            fails++;
            $display("FAIL enable_discard: busy=%b rdy=%b gap=%b loads=%0d cnt=%0d expected 1 1 0 %0d 1",
                     busy, s_ready, err_gap, load_cnt, frame_count, l0);
        end
    endtask

    task automatic test_reset_mid;
        int l0;
        apply_reset();
        enable = 1;
        tick();
        l0 = load_cnt;
        send_bits(8'hFF, 4, 1);
        s_valid = 1; s_bit = 1;
        #2 reset = 1;
        enable = 0;
        #1;
        tests++;
        if (busy !== 1'b0 || s_ready !== 1'b0 || sr_load !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: busy=%b rdy=%b load=%b expected 0 0 0",
                     busy, s_ready, sr_load);
        end
        tick();
        reset = 0;
        s_valid = 0;
        tick();
        tests++;
        if (busy !== 1'b0 || load_cnt !== l0) begin
            fails++;
            $display("FAIL reset_mid_noload: busy=%b loads=%0d expected 0 %0d", busy, load_cnt, l0);
        end
        enable = 1;
        tick();
        send_bits(8'hE0, 3, 1);
        clr_status = 1;
        tick();
        clr_status = 0;
        tests++;
        if (err_gap !== 1'b1) begin
            fails++;
            $display("FAIL clr_vs_set: err_gap=%b expected 1", err_gap);
        end
        clr_status = 1;
        tick();
        clr_status = 0;
        tests++;
        if (err_gap !== 1'b0) begin
            fails++;
            $display("FAIL clr_only: err_gap=%b expected 0", err_gap);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] pat;
        apply_reset();
        enable = 1;
        frame_ready = 1;
        tick();
        for (int i = 1; i <= 15; i++) begin
            pat = 8'(i * 37);
            send_bits(pat, 8, 1);
            tick();
        end
        tests++;
        if (frame_count !== 4'hF || data_out !== 8'h2B) begin
            fails++;
            $display("FAIL wrap_pre: cnt=%0d data=%h expected 15 2b", frame_count, data_out);
        end
        send_bits(8'hC3, 8, 1);
        tick();
        tests++;
        if (frame_count !== 4'h0 || err_overrun !== 1'b0 || data_out !== 8'hC3) begin
            fails++;
            $display("FAIL wrap_post: cnt=%0d ovr=%b data=%h expected 0 0 c3",
                     frame_count, err_overrun, data_out);
        end
        frame_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_gap();
        test_resync();
        test_enable();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
